// File: rtl/async_reset_sync_shift_reg_vec.sv
// WIDTH-bit, DEPTH-stage shift register with asynchronous reset to INIT, clock enable,
// synchronous parallel load, per-bit change-detect pulses and a pipeline-filled flag.
module async_reset_sync_shift_reg_vec #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 3,
   parameter logic [WIDTH-1:0] INIT = {WIDTH{1'b0}}
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             io_en,
   input  logic [WIDTH-1:0] io_d,
   input  logic             io_load,
   input  logic [WIDTH-1:0] io_load_val,
   output logic [WIDTH-1:0] io_q,
   output logic [WIDTH-1:0] io_changed,
   output logic             io_valid
);

   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] ONE_C   = CW'(1);
   localparam logic [CW-1:0] ZERO_C  = CW'(0);

   logic [DEPTH-1:0][WIDTH-1:0] stage_q;
   logic [DEPTH-1:0][WIDTH-1:0] stage_d;
   logic [WIDTH-1:0]            prev_q;
   logic [CW-1:0]               fill_q;
   logic [CW-1:0]               fill_d;

   // Next-state selection: load beats shift, shift beats hold.
   always_comb begin
      stage_d = stage_q;
      fill_d  = fill_q;
      if (io_load) begin
         for (int i = 0; i < DEPTH; i++) begin
            stage_d[i] = io_load_val;
         end
         fill_d = DEPTH_C;
      end else if (io_en) begin
         stage_d[0] = io_d;
         for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
         end
         if (fill_q != DEPTH_C) begin
            fill_d = fill_q + ONE_C;
         end else begin
            fill_d = fill_q;
         end
      end else begin
         stage_d = stage_q;
         fill_d  = fill_q;
      end
   end

   // State registers; prev_q tracks io_q on every edge, including hold and load edges.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         stage_q <= {DEPTH{INIT}};
         prev_q  <= INIT;
         fill_q  <= ZERO_C;
      end else begin
         stage_q <= stage_d;
         prev_q  <= stage_q[DEPTH-1];
         fill_q  <= fill_d;
      end
   end

   assign io_q       = stage_q[DEPTH-1];
   assign io_changed = stage_q[DEPTH-1] ^ prev_q;
   assign io_valid   = (fill_q == DEPTH_C);

endmodule

// File: tb/tb_async_reset_sync_shift_reg_vec.sv
// Directed bench for async_reset_sync_shift_reg_vec: DEPTH=3 and DEPTH=1 instances share
// stimulus and are checked each cycle against a queue-based model plus literal expectations.
module tb_async_reset_sync_shift_reg_vec;

   localparam logic [7:0] INIT_V = 8'hA5;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       en = 1'b0;
   logic       load = 1'b0;
   logic [7:0] d = 8'h00;
   logic [7:0] lv = 8'h00;
   logic [7:0] q3, ch3, q1, ch1;
   logic       v3, v1;

   int checks = 0;
   int errors = 0;
   bit armed = 1'b0;

   async_reset_sync_shift_reg_vec #(.WIDTH(8), .DEPTH(3), .INIT(INIT_V)) dut3 (
      .clock(clock), .reset(reset), .io_en(en), .io_d(d), .io_load(load),
      .io_load_val(lv), .io_q(q3), .io_changed(ch3), .io_valid(v3));

   async_reset_sync_shift_reg_vec #(.WIDTH(8), .DEPTH(1), .INIT(INIT_V)) dut1 (
      .clock(clock), .reset(reset), .io_en(en), .io_d(d), .io_load(load),
      .io_load_val(lv), .io_q(q1), .io_changed(ch1), .io_valid(v1));

   always #5 clock = ~clock;

   // Model: queue of the last DEPTH values accepted; oldest entry is the output.
   logic [7:0] p3[$];
   logic [7:0] p1[$];
   logic [7:0] m3_prev, m1_prev;
   int         f3, f1;

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         p3 = {INIT_V, INIT_V, INIT_V};
         p1 = {INIT_V};
         m3_prev = INIT_V;
         m1_prev = INIT_V;
         f3 = 0;
         f1 = 0;
      end else begin
         m3_prev = p3[0];
         m1_prev = p1[0];
         if (load) begin
            p3 = {lv, lv, lv};
            p1 = {lv};
            f3 = 3;
            f1 = 1;
         end else if (en) begin
            p3.push_back(d);
            void'(p3.pop_front());
            p1.push_back(d);
            void'(p1.pop_front());
            if (f3 < 3) f3++;
            if (f1 < 1) f1++;
         end
      end
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
      end
   endtask

   // Cycle-by-cycle comparison against the model, away from the active edge.
   always @(negedge clock) begin
      if (armed) begin
         check("q3", 32'(q3), 32'(p3[0]));
         check("changed3", 32'(ch3), 32'(p3[0] ^ m3_prev));
         check("valid3", 32'(v3), 32'(f3 == 3));
         check("q1", 32'(q1), 32'(p1[0]));
         check("changed1", 32'(ch1), 32'(p1[0] ^ m1_prev));
         check("valid1", 32'(v1), 32'(f1 == 1));
      end
   end

   task automatic step(input logic e, input logic [7:0] dv, input logic l, input logic [7:0] lval);
      @(negedge clock);
      en = e; d = dv; load = l; lv = lval;
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      #1;
      check("rst_q3", 32'(q3), 32'(INIT_V));
      check("rst_changed3", 32'(ch3), 32'h0);
      check("rst_valid3", 32'(v3), 32'h0);
      @(negedge clock);
      en = 1'b0; load = 1'b0;
      @(negedge clock);
      reset = 1'b0;
   endtask

   initial begin
      // Reset asserted mid-cycle before any clock edge.
      #2;
      do_reset();
      armed = 1'b1;

      // Shift latency.
      step(1'b1, 8'h01, 1'b0, 8'h00);
      check("lat_valid_e1", 32'(v3), 32'h0);
      step(1'b1, 8'h02, 1'b0, 8'h00);
      check("lat_q_e2", 32'(q3), 32'hA5);
      check("lat_valid_e2", 32'(v3), 32'h0);
      step(1'b1, 8'h03, 1'b0, 8'h00);
      check("lat_q_e3", 32'(q3), 32'h01);
      check("lat_valid_e3", 32'(v3), 32'h1);
      check("lat_changed_e3", 32'(ch3), 32'hA4);
      step(1'b1, 8'h04, 1'b0, 8'h00);
      check("lat_q_e4", 32'(q3), 32'h02);
      check("lat_changed_e4", 32'(ch3), 32'h03);
      step(1'b1, 8'h00, 1'b0, 8'h00);
      check("lat_q_e5", 32'(q3), 32'h03);
      step(1'b1, 8'h00, 1'b0, 8'h00);
      check("lat_q_e6", 32'(q3), 32'h04);

      // Enable gating: 3C needs three enabled edges.
      step(1'b1, 8'h3C, 1'b0, 8'h00);
      step(1'b0, 8'hEE, 1'b0, 8'h00);
      check("gate_hold_q", 32'(q3), 32'h00);
      check("gate_hold_changed", 32'(ch3), 32'h00);
      step(1'b0, 8'hEE, 1'b0, 8'h00);
      check("gate_hold2_changed", 32'(ch3), 32'h00);
      step(1'b1, 8'h11, 1'b0, 8'h00);
      check("gate_e4_q", 32'(q3), 32'h00);
      step(1'b1, 8'h22, 1'b0, 8'h00);
      check("gate_e5_q", 32'(q3), 32'h3C);

      // Load priority over enable, straight from reset.
      do_reset();
      step(1'b1, 8'h00, 1'b1, 8'hFF);
      check("load_q", 32'(q3), 32'hFF);
      check("load_valid", 32'(v3), 32'h1);
      check("load_changed", 32'(ch3), 32'h5A);
      step(1'b0, 8'h00, 1'b0, 8'h00);
      check("load_changed_after", 32'(ch3), 32'h00);
      check("load_q_after", 32'(q3), 32'hFF);

      // Reset mid-operation discards data and drops valid.
      step(1'b0, 8'h00, 1'b1, 8'h77);
      check("pre_rst_q", 32'(q3), 32'h77);
      check("pre_rst_valid", 32'(v3), 32'h1);
      #2;
      do_reset();
      step(1'b1, 8'h10, 1'b0, 8'h00);
      check("refill_v1", 32'(v3), 32'h0);
      step(1'b0, 8'h99, 1'b0, 8'h00);
      check("refill_hold_v", 32'(v3), 32'h0);
      step(1'b1, 8'h20, 1'b0, 8'h00);
      check("refill_v2", 32'(v3), 32'h0);
      step(1'b1, 8'h30, 1'b0, 8'h00);
      check("refill_v3", 32'(v3), 32'h1);
      check("refill_q3", 32'(q3), 32'h10);

      // DEPTH=1 instance: same-edge update.
      do_reset();
      step(1'b1, 8'h5A, 1'b0, 8'h00);
      check("d1_q", 32'(q1), 32'h5A);
      check("d1_valid", 32'(v1), 32'h1);
      check("d1_changed", 32'(ch1), 32'hFF);
      step(1'b0, 8'h00, 1'b0, 8'h00);
      check("d1_changed_after", 32'(ch1), 32'h00);

      @(negedge clock);
      armed = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
